game_screen_sequencer: RTL and testbench
========================================

# game_screen_sequencer

Parametrised game-phase sequencer and pixel colour stage between the VGA driver, the game controller and the VGA DAC outputs. It runs the screen state machine (start, play, pause, win, loss), restarts without a board reset, holds the game controller in reset outside play, keeps an elapsed-time clock with optional time limit, and produces the registered, blanked RGB pixel.

## Interface
Parameters:
- CLK_HZ, 50_000_000: clk cycles per elapsed-time second.
- TIME_LIMIT, 0: seconds of play before forced loss; 0 disables; legal range 0..999.
- COLOR_W, 8: bits per colour channel.
- START_COLOR, 24'h0000FF: {R,G,B} of start screen, 3*COLOR_W bits.
- WIN_COLOR, 24'h00FF00: win screen colour.
- LOSS_COLOR, 24'hFF0000: loss screen colour.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  start/restart level (switch); acted on at rising edge only.
- pause  in  1  pause level.
- endgame  in  1  game controller reports game over.
- win  in  1  qualifies endgame: 1 win, 0 loss.
- active_pixels  in  1  VGA driver visible-area flag.
- game_color  in  3*COLOR_W  game controller pixel colour.
- color_out  out  3*COLOR_W  registered pixel to VGA R/G/B.
- game_rst_n  out  1  active-low reset to game controller.
- state  out  3  current state encoding.
- secs_bcd  out  12  elapsed seconds, 3 BCD digits.
- timed_out  out  1  last loss caused by time limit.

## Operation
- States: START=0, PLAYING=1, PAUSED=2, WON=3, LOST=4; others -> START.
- Start edge: start_q registered copy of start, reset value 1; start_edge = start & ~start_q. Switch held high through reset must drop and rise again.
- START: start_edge -> PLAYING; clears secs, prescaler, timed_out.
- PLAYING, priority order: endgame -> WON if win else LOST; timeout (TIME_LIMIT!=0 and secs == TIME_LIMIT) -> LOST, set timed_out; pause -> PAUSED; else stay.
- PAUSED: pause=0 -> PLAYING. endgame ignored while paused; re-evaluated on return to PLAYING.
- WON/LOST: start_edge -> START. Time and timed_out hold final values.
- game_rst_n: registered; 0 when next state is START, 1 otherwise.
- Timer: prescaler counts 0..CLK_HZ-1 only in PLAYING; held (not cleared) in PAUSED. At wrap secs +1 (binary counter and BCD digits in step, BCD carry 9->0). Saturate at 999.
- Colour (registered): active_pixels=0 -> all zero; START -> START_COLOR; PLAYING -> game_color; PAUSED -> each channel of game_color shifted right 1 (half brightness); WON -> WIN_COLOR; LOST -> LOSS_COLOR.

## Timing
- Reset values: state START, color_out 0, game_rst_n 0, secs_bcd 0, timed_out 0, prescaler 0, start_q 1.
- All state, counters and outputs update on posedge clk; rst clears asynchronously.
- start_edge seen in cycle N -> state PLAYING at N+1, game_rst_n 1 at N+1.
- color_out latency 1 cycle from active_pixels/game_color/state.
- secs increments in cycle after prescaler reaches CLK_HZ-1; first increment CLK_HZ PLAYING cycles after entering PLAYING.
- Timeout: secs reaches TIME_LIMIT at cycle N -> LOST at N+1; endgame in cycle N wins over timeout, timed_out stays 0.
- Pause and endgame same cycle in PLAYING -> endgame wins.
- Reset mid-game: immediate return to START, game held in reset.

## Test plan
- Reset with start=1, then hold: state stays 0, color_out 0; drop/raise start -> state 1 next cycle, game_rst_n 1.
- CLK_HZ=4, TIME_LIMIT=3: play 12 cycles -> secs_bcd 003, state 4, timed_out 1, color_out 24'hFF0000 with active_pixels=1.
- PLAYING, game_color 24'hFE80FF, pause=1 -> color_out 24'h7F407F; prescaler at 2, pause 10 cycles, release -> secs increments 2 PLAYING cycles later.
- endgame=1,win=1 with pause=1 same cycle -> state 3, color_out 24'h00FF00; start rising edge -> state 0, game_rst_n 0, then restart clears secs_bcd to 000.
- active_pixels=0 in every state -> color_out 0 one cycle later.
- CLK_HZ=1, TIME_LIMIT=0: 1200 cycles -> secs_bcd 12'h999 saturated, BCD rollover 009->010, 099->100 checked.

Source files
------------

// File: rtl/game_screen_sequencer.sv
// rtl/game_screen_sequencer.sv - game phase sequencer with elapsed-time clock and blanked RGB pixel stage
//
// Runs the screen state machine (START, PLAYING, PAUSED, WON, LOST), holds the
// game controller in reset outside of play, keeps a BCD elapsed-seconds clock
// with an optional time limit and registers the outgoing pixel colour.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   start         start/restart switch level, acted on at its rising edge
//   pause         pause switch level
//   endgame       game controller reports game over
//   win           qualifies endgame: 1 win, 0 loss
//   active_pixels VGA visible-area flag
//   game_color    game controller pixel {R,G,B}
//   color_out     registered pixel {R,G,B} to the DAC
//   game_rst_n    active-low reset to the game controller
//   state         current state encoding
//   secs_bcd      elapsed seconds, three BCD digits
//   timed_out     last loss was caused by the time limit
module game_screen_sequencer #(
  parameter int                   CLK_HZ      = 50_000_000,
  parameter int                   TIME_LIMIT  = 0,
  parameter int                   COLOR_W     = 8,
  parameter logic [3*COLOR_W-1:0] START_COLOR = 24'h0000FF,
  parameter logic [3*COLOR_W-1:0] WIN_COLOR   = 24'h00FF00,
  parameter logic [3*COLOR_W-1:0] LOSS_COLOR  = 24'hFF0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   endgame,
  input  logic                   win,
  input  logic                   active_pixels,
  input  logic [3*COLOR_W-1:0]   game_color,
  output logic [3*COLOR_W-1:0]   color_out,
  output logic                   game_rst_n,
  output logic [2:0]             state,
  output logic [11:0]            secs_bcd,
  output logic                   timed_out
);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_PLAYING = 3'd1,
    S_PAUSED  = 3'd2,
    S_WON     = 3'd3,
    S_LOST    = 3'd4
  } state_t;

  // A 1 Hz prescaler for CLK_HZ=1 still needs one bit of storage.
  localparam int             PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [9:0]     LIMIT   = 10'(TIME_LIMIT);
  localparam logic [9:0]     SECS_MAX = 10'd999;

  state_t                 cur;
  state_t                 nxt;
  logic                   start_q;
  logic                   start_edge;
  logic [PW-1:0]          pre;
  logic [9:0]             secs_bin;
  logic [11:0]            bcd_inc;
  logic                   timeout;
  logic [3*COLOR_W-1:0]   half_color;
  logic [3*COLOR_W-1:0]   pix;

  // start_q resets high so a switch left on through reset must cycle first.
  assign start_edge = start & ~start_q;
  assign timeout    = (TIME_LIMIT != 0) && (secs_bin == LIMIT);
  assign state      = cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= S_START;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_START:   if (start_edge) nxt = S_PLAYING;
      S_PLAYING: begin
        // endgame outranks the time limit, which outranks pause
        if (endgame)      nxt = win ? S_WON : S_LOST;
        else if (timeout) nxt = S_LOST;
        else if (pause)   nxt = S_PAUSED;
      end
      S_PAUSED:  if (!pause) nxt = S_PLAYING;
      S_WON,
      S_LOST:    if (start_edge) nxt = S_START;
      default:   nxt = S_START;
    endcase
  end

  // Ripple the BCD digits alongside the binary count.
  always_comb begin
    bcd_inc = secs_bcd;
    if (secs_bcd[3:0] == 4'd9) begin
      bcd_inc[3:0] = 4'd0;
      if (secs_bcd[7:4] == 4'd9) begin
        bcd_inc[7:4]  = 4'd0;
        bcd_inc[11:8] = secs_bcd[11:8] + 4'd1;
      end else begin
        bcd_inc[7:4] = secs_bcd[7:4] + 4'd1;
      end
    end else begin
      bcd_inc[3:0] = secs_bcd[3:0] + 4'd1;
    end
  end

  always_comb begin
    half_color = '0;
    for (int i = 0; i < 3; i++) begin
      half_color[i*COLOR_W +: COLOR_W] = game_color[i*COLOR_W +: COLOR_W] >> 1;
    end
    pix = '0;
    if (active_pixels) begin
      case (cur)
        S_START:   pix = START_COLOR;
        S_PLAYING: pix = game_color;
        S_PAUSED:  pix = half_color;
        S_WON:     pix = WIN_COLOR;
        S_LOST:    pix = LOSS_COLOR;
        default:   pix = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q    <= 1'b1;
      game_rst_n <= 1'b0;
      color_out  <= '0;
      pre        <= '0;
      secs_bin   <= '0;
      secs_bcd   <= '0;
      timed_out  <= 1'b0;
    end else begin
      start_q    <= start;
      game_rst_n <= (nxt != S_START);
      color_out  <= pix;
      if (cur == S_START && start_edge) begin
        pre       <= '0;
        secs_bin  <= '0;
        secs_bcd  <= '0;
        timed_out <= 1'b0;
      end else if (cur == S_PLAYING) begin
        if (!endgame && timeout) timed_out <= 1'b1;
        // Prescaler is only advanced here, so PAUSED simply holds it.
        if (pre == PRE_MAX) begin
          pre <= '0;
          if (secs_bin != SECS_MAX) begin
            secs_bin <= secs_bin + 10'd1;
            secs_bcd <= bcd_inc;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_screen_sequencer.sv
// tb/tb_game_screen_sequencer.sv - scoreboard bench for game_screen_sequencer
module tb_game_screen_sequencer;

  logic        clk;
  logic        rst;
  logic        start, pause, endgame, win, active_pixels;
  logic [23:0] game_color;
  logic [23:0] color_out;
  logic        game_rst_n;
  logic [2:0]  state;
  logic [11:0] secs_bcd;
  logic        timed_out;

  logic        b_start;
  logic [23:0] b_color_out;
  logic        b_game_rst_n;
  logic [2:0]  b_state;
  logic [11:0] b_secs_bcd;
  logic        b_timed_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [23:0] val;
  } exp_t;
  exp_t sb[$];

  game_screen_sequencer #(.CLK_HZ(4), .TIME_LIMIT(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .endgame(endgame),
    .win(win), .active_pixels(active_pixels), .game_color(game_color),
    .color_out(color_out), .game_rst_n(game_rst_n), .state(state),
    .secs_bcd(secs_bcd), .timed_out(timed_out)
  );

  game_screen_sequencer #(.CLK_HZ(1), .TIME_LIMIT(0)) u_sat (
    .clk(clk), .rst(rst), .start(b_start), .pause(1'b0), .endgame(1'b0),
    .win(1'b0), .active_pixels(1'b1), .game_color(24'h0),
    .color_out(b_color_out), .game_rst_n(b_game_rst_n), .state(b_state),
    .secs_bcd(b_secs_bcd), .timed_out(b_timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag, input logic [23:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check({"sb_empty_", tag}, obs, ~obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] exp);
    expect_val(tag, {21'd0, exp});
    pop_check(tag, {21'd0, state});
  endtask

  task automatic chk_color(input string tag, input logic [23:0] exp);
    expect_val(tag, exp);
    pop_check(tag, color_out);
  endtask

  task automatic chk_secs(input string tag, input logic [11:0] exp);
    expect_val(tag, {12'd0, exp});
    pop_check(tag, {12'd0, secs_bcd});
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    expect_val(tag, {23'd0, exp});
    pop_check(tag, {23'd0, obs});
  endtask

  // Drop then raise the start switch; the edge is acted on at the second tick.
  task automatic start_pulse();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    int sat_v;
    rst = 1'b0; start = 1'b1; pause = 1'b0; endgame = 1'b0; win = 1'b0;
    active_pixels = 1'b0; game_color = 24'h123456; b_start = 1'b0;
    tick(2);
    chk_state("rst_state", 3'd0);
    chk_color("rst_color", 24'h0);
    chk_bit("rst_game_rst_n", game_rst_n, 1'b0);
    chk_secs("rst_secs", 12'h000);
    chk_bit("rst_timed_out", timed_out, 1'b0);

    rst = 1'b1;
    tick(3);
    chk_state("held_start_state", 3'd0);
    chk_color("held_start_color", 24'h0);
    active_pixels = 1'b1;
    tick();
    chk_color("start_color", 24'h0000FF);

    start_pulse();
    chk_state("enter_play", 3'd1);
    chk_bit("play_game_rst_n", game_rst_n, 1'b1);

    tick(12);
    chk_secs("secs_at_limit", 12'h003);
    chk_state("still_playing", 3'd1);
    chk_color("play_color", 24'h123456);
    tick();
    chk_state("timeout_lost", 3'd4);
    chk_bit("timeout_flag", timed_out, 1'b1);
    tick();
    chk_color("loss_color", 24'hFF0000);
    chk_secs("secs_hold_lost", 12'h003);
    active_pixels = 1'b0;
    tick();
    chk_color("blank_lost", 24'h0);
    active_pixels = 1'b1;

    start_pulse();
    chk_state("restart_to_start", 3'd0);
    chk_bit("restart_game_rst_n", game_rst_n, 1'b0);
    start_pulse();
    chk_state("restart_play", 3'd1);
    chk_secs("restart_secs_clear", 12'h000);
    chk_bit("restart_timed_out_clear", timed_out, 1'b0);

    tick(12);
    endgame = 1'b1; win = 1'b1;
    tick();
    chk_state("endgame_beats_timeout", 3'd3);
    chk_bit("endgame_no_timeout_flag", timed_out, 1'b0);
    endgame = 1'b0;
    tick();
    chk_color("win_color", 24'h00FF00);
    active_pixels = 1'b0;
    tick();
    chk_color("blank_won", 24'h0);
    active_pixels = 1'b1;

    start_pulse();
    start_pulse();
    chk_state("pause_test_play", 3'd1);
    game_color = 24'hFE80FF;
    tick();
    pause = 1'b1;
    tick();
    chk_state("paused", 3'd2);
    tick();
    chk_color("half_color", 24'h7F407F);
    endgame = 1'b1; win = 1'b0;
    tick();
    chk_state("endgame_ignored_paused", 3'd2);
    endgame = 1'b0;
    active_pixels = 1'b0;
    tick();
    chk_color("blank_paused", 24'h0);
    active_pixels = 1'b1;
    tick(6);
    chk_secs("paused_secs", 12'h000);
    pause = 1'b0;
    tick();
    chk_state("unpause", 3'd1);
    chk_secs("unpause_secs0", 12'h000);
    tick();
    chk_secs("unpause_secs1", 12'h000);
    chk_color("play_color2", 24'hFE80FF);
    active_pixels = 1'b0;
    tick();
    chk_secs("unpause_secs_inc", 12'h001);
    chk_color("blank_playing", 24'h0);
    active_pixels = 1'b1;

    pause = 1'b1; endgame = 1'b1; win = 1'b1;
    tick();
    chk_state("endgame_beats_pause", 3'd3);
    pause = 1'b0; endgame = 1'b0;
    tick();
    chk_color("win_color2", 24'h00FF00);

    start_pulse();
    chk_state("back_to_start", 3'd0);
    active_pixels = 1'b0;
    tick();
    chk_color("blank_start", 24'h0);
    active_pixels = 1'b1;
    start_pulse();
    chk_state("play_before_reset", 3'd1);
    rst = 1'b0;
    #1;
    chk_state("async_reset_state", 3'd0);
    chk_bit("async_reset_game_rst_n", game_rst_n, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    b_start = 1'b1;
    tick();
    expect_val("sat_play", 24'd1);
    pop_check("sat_play", {21'd0, b_state});
    for (int k = 1; k <= 1200; k++) begin
      tick();
      if (k == 9 || k == 10 || k == 99 || k == 100 || k == 999 || k == 1000 || k == 1200) begin
        sat_v = (k > 999) ? 999 : k;
        expect_val($sformatf("sat_secs_%0d", k), {12'd0, to_bcd(sat_v)});
        pop_check("sat_secs", {12'd0, b_secs_bcd});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
